// File: rtl/prescaler_pkg.sv
// Shared constants for the prescaler sequencer: FSM state encoding and default widths.
package prescaler_pkg;

  localparam int DEFAULT_CNT_W = 28;
  localparam int DEFAULT_REP_W = 16;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_LOAD = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

endpackage

// File: rtl/edge_sync_detect.sv
// Two-flop synchroniser for an external clock-like signal, followed by a
// single-cycle rising-edge pulse generator.
module edge_sync_detect (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic sync1_reg;
  logic sync2_reg;
  logic prev_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= 1'b0;
      sync2_reg <= 1'b0;
      prev_reg  <= 1'b0;
    end else begin
      sync1_reg <= din;
      sync2_reg <= sync1_reg;
      prev_reg  <= sync2_reg;
    end
  end

  assign rise = sync2_reg & ~prev_reg;

endmodule

// File: rtl/prescaler_sequencer.sv
// Steps a clock prescaler through a table of {count, repeat} entries, dwelling on
// each entry for a programmed number of prescaler output rising edges.
module prescaler_sequencer
  import prescaler_pkg::*;
#(
  parameter int CNT_W = DEFAULT_CNT_W,
  parameter int REP_W = DEFAULT_REP_W,
  parameter int DEPTH = 4,
  parameter int IDX_W = 2
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             cfg_we,
  input  logic [IDX_W-1:0] cfg_addr,
  input  logic [CNT_W-1:0] cfg_cuentas,
  input  logic [REP_W-1:0] cfg_reps,
  input  logic             start,
  input  logic             stop,
  input  logic             loop,
  input  logic             presc_clk,
  output logic [CNT_W-1:0] cuentas,
  output logic             presc_reset,
  output logic             busy,
  output logic [IDX_W-1:0] step_idx,
  output logic             done
);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [IDX_W-1:0] step_idx_next;
  logic [CNT_W-1:0] cuentas_next;
  logic [REP_W-1:0] edge_cnt;
  logic [REP_W-1:0] edge_cnt_next;
  logic [REP_W-1:0] edge_cnt_inc;
  logic             rise;

  logic [CNT_W-1:0] tbl_cnt [DEPTH];
  logic [REP_W-1:0] tbl_rep [DEPTH];

  edge_sync_detect u_edge (
    .clk   (clock),
    .rst_n (reset),
    .din   (presc_clk),
    .rise  (rise)
  );

  // Table is register-based so that reset can clear every entry.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        tbl_cnt[i] <= '0;
        tbl_rep[i] <= '0;
      end
    end else if (cfg_we && state == ST_IDLE) begin
      tbl_cnt[cfg_addr] <= cfg_cuentas;
      tbl_rep[cfg_addr] <= cfg_reps;
    end
  end

  always_comb begin
    state_next    = state;
    step_idx_next = step_idx;
    cuentas_next  = cuentas;
    edge_cnt_next = edge_cnt;
    edge_cnt_inc  = edge_cnt + 1'b1;
    case (state)
      ST_IDLE: begin
        if (start) begin
          step_idx_next = '0;
          state_next    = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cuentas_next  = tbl_cnt[step_idx];
        edge_cnt_next = '0;
        state_next    = (tbl_rep[step_idx] == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        if (rise) begin
          edge_cnt_next = edge_cnt_inc;
          if (edge_cnt_inc == tbl_rep[step_idx]) begin
            if (step_idx == IDX_W'(DEPTH - 1)) begin
              state_next = ST_DONE;
            end else begin
              step_idx_next = step_idx + 1'b1;
              state_next    = ST_LOAD;
            end
          end
        end
      end
      ST_DONE: begin
        if (loop) begin
          step_idx_next = '0;
          state_next    = ST_LOAD;
        end else begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
    // Stop overrides everything; index and count are frozen for post-mortem inspection.
    if (stop) begin
      state_next    = ST_IDLE;
      step_idx_next = step_idx;
      cuentas_next  = cuentas;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      step_idx <= '0;
      cuentas  <= '0;
      edge_cnt <= '0;
    end else begin
      state    <= state_next;
      step_idx <= step_idx_next;
      cuentas  <= cuentas_next;
      edge_cnt <= edge_cnt_next;
    end
  end

  assign busy        = (state != ST_IDLE);
  assign presc_reset = (state != ST_RUN);
  assign done        = (state == ST_DONE) && !loop && !stop;

endmodule

// File: tb/tb_prescaler_sequencer.sv
// Randomised and directed bench for prescaler_sequencer, driving presc_clk from a
// behavioural prescaler and checking observed dwell segments against the table.
module tb_prescaler_sequencer;

  localparam int CNT_W = 28;
  localparam int REP_W = 16;
  localparam int DEPTH = 4;
  localparam int IDX_W = 2;

  logic             clock = 1'b0;
  logic             reset;
  logic             cfg_we;
  logic [IDX_W-1:0] cfg_addr;
  logic [CNT_W-1:0] cfg_cuentas;
  logic [REP_W-1:0] cfg_reps;
  logic             start;
  logic             stop;
  logic             loop;
  logic             presc_clk = 1'b0;
  logic [CNT_W-1:0] cuentas;
  logic             presc_reset;
  logic             busy;
  logic [IDX_W-1:0] step_idx;
  logic             done;

  int n_vec = 0;
  int n_err = 0;

  // Reference table contents as the bench believes them to be.
  logic [CNT_W-1:0] m_cnt [DEPTH];
  logic [REP_W-1:0] m_rep [DEPTH];

  // Observed dwell segments: count value and number of prescaler rises seen.
  logic [CNT_W-1:0] seg_c [$];
  int               seg_r [$];
  logic [CNT_W-1:0] exp_c [$];
  int               exp_r [$];
  int               done_cnt = 0;
  logic             in_run = 1'b0;
  logic             presc_prev = 1'b0;
  logic [CNT_W-1:0] pcnt = '0;

  prescaler_sequencer #(
    .CNT_W (CNT_W),
    .REP_W (REP_W),
    .DEPTH (DEPTH),
    .IDX_W (IDX_W)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .cfg_we      (cfg_we),
    .cfg_addr    (cfg_addr),
    .cfg_cuentas (cfg_cuentas),
    .cfg_reps    (cfg_reps),
    .start       (start),
    .stop        (stop),
    .loop        (loop),
    .presc_clk   (presc_clk),
    .cuentas     (cuentas),
    .presc_reset (presc_reset),
    .busy        (busy),
    .step_idx    (step_idx),
    .done        (done)
  );

  always #5 clock = ~clock;

  // Behavioural prescaler: output toggles every (cuentas+1) clocks while released.
  always @(posedge clock) begin
    if (presc_reset) begin
      pcnt      <= '0;
      presc_clk <= 1'b0;
    end else if (pcnt >= cuentas) begin
      pcnt      <= '0;
      presc_clk <= ~presc_clk;
    end else begin
      pcnt <= pcnt + 1'b1;
    end
  end

  always @(negedge clock) begin
    if (!presc_reset && !in_run) begin
      seg_c.push_back(cuentas);
      seg_r.push_back(0);
      in_run = 1'b1;
    end else if (presc_reset) begin
      in_run = 1'b0;
    end
    if (in_run && presc_clk && !presc_prev)
      seg_r[seg_r.size()-1] = seg_r[seg_r.size()-1] + 1;
    if (done) done_cnt++;
    presc_prev = presc_clk;
  end

  task automatic clear_record();
    @(posedge clock);
    #1;
    seg_c.delete();
    seg_r.delete();
    done_cnt = 0;
  endtask

  task automatic write_entry(input int addr, input int c, input int r, input bit accepted);
    @(negedge clock);
    cfg_we      = 1'b1;
    cfg_addr    = IDX_W'(addr);
    cfg_cuentas = CNT_W'(c);
    cfg_reps    = REP_W'(r);
    @(negedge clock);
    cfg_we = 1'b0;
    if (accepted) begin
      m_cnt[addr] = CNT_W'(c);
      m_rep[addr] = REP_W'(r);
    end
  endtask

  task automatic pulse_start();
    @(negedge clock);
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cycles, input string tag);
    int n;
    n = 0;
    while (busy && n < max_cycles) begin
      @(negedge clock);
      n++;
    end
    n_vec++;
    if (busy) begin
      n_err++;
      $display("FAIL %s_timeout: busy=%0b after %0d cycles, required 0", tag, busy, n);
    end
  endtask

  task automatic build_expected();
    exp_c.delete();
    exp_r.delete();
    for (int i = 0; i < DEPTH; i++) begin
      if (m_rep[i] == '0) break;
      exp_c.push_back(m_cnt[i]);
      exp_r.push_back(int'(m_rep[i]));
    end
  endtask

  task automatic load_directed_table();
    write_entry(0, 10, 3, 1'b1);
    write_entry(1, 20, 2, 1'b1);
    write_entry(2, 0, 0, 1'b1);
  endtask

  task automatic test_reset();
    #1;
    n_vec++;
    if ({cuentas, presc_reset, busy, done, step_idx} !== {CNT_W'(0), 1'b1, 1'b0, 1'b0, IDX_W'(0)}) begin
      n_err++;
      $display("FAIL reset_hold: cuentas=%0d presc_reset=%0b busy=%0b done=%0b step_idx=%0d, required 0 1 0 0 0",
               cuentas, presc_reset, busy, done, step_idx);
    end
    @(negedge clock);
    reset = 1'b1;
    repeat (2) @(negedge clock);
    n_vec++;
    if ({cuentas, presc_reset, busy, done, step_idx} !== {CNT_W'(0), 1'b1, 1'b0, 1'b0, IDX_W'(0)}) begin
      n_err++;
      $display("FAIL reset_release: cuentas=%0d presc_reset=%0b busy=%0b done=%0b step_idx=%0d, required 0 1 0 0 0",
               cuentas, presc_reset, busy, done, step_idx);
    end
  endtask

  task automatic test_directed_sequence();
    load_directed_table();
    loop = 1'b0;
    clear_record();
    pulse_start();
    wait_idle(2000, "directed");
    build_expected();
    n_vec++;
    if (seg_c.size() != exp_c.size()) begin
      n_err++;
      $display("FAIL directed_nseg: got %0d segments, required %0d", seg_c.size(), exp_c.size());
    end
    for (int i = 0; i < exp_c.size(); i++) begin
      n_vec++;
      if (seg_c[i] !== exp_c[i] || seg_r[i] != exp_r[i]) begin
        n_err++;
        $display("FAIL directed_seg%0d: cuentas=%0d rises=%0d, required cuentas=%0d rises=%0d",
                 i, seg_c[i], seg_r[i], exp_c[i], exp_r[i]);
      end
    end
    n_vec++;
    if (done_cnt != 1) begin
      n_err++;
      $display("FAIL directed_done: %0d done pulses, required 1", done_cnt);
    end
  endtask

  task automatic test_loop_stop();
    int n;
    logic [CNT_W-1:0] pc;
    int pr;
    loop = 1'b1;
    clear_record();
    pulse_start();
    n = 0;
    while (seg_c.size() < 5 && n < 3000) begin
      @(negedge clock);
      n++;
    end
    n_vec++;
    if (seg_c.size() < 5) begin
      n_err++;
      $display("FAIL loop_timeout: %0d segments after %0d cycles, required 5", seg_c.size(), n);
    end
    @(negedge clock);
    stop = 1'b1;
    @(posedge clock);
    #1;
    stop = 1'b0;
    n_vec++;
    if (busy !== 1'b0 || presc_reset !== 1'b1) begin
      n_err++;
      $display("FAIL loop_stop: busy=%0b presc_reset=%0b, required 0 1", busy, presc_reset);
    end
    for (int i = 0; i < seg_c.size(); i++) begin
      pc = (i % 2 == 0) ? CNT_W'(10) : CNT_W'(20);
      pr = (i % 2 == 0) ? 3 : 2;
      n_vec++;
      if (seg_c[i] !== pc || (i < seg_c.size() - 1 && seg_r[i] != pr) || seg_r[i] > pr) begin
        n_err++;
        $display("FAIL loop_seg%0d: cuentas=%0d rises=%0d, required cuentas=%0d rises=%0d",
                 i, seg_c[i], seg_r[i], pc, pr);
      end
    end
    repeat (3) @(negedge clock);
    n_vec++;
    if (done_cnt != 0 || busy !== 1'b0) begin
      n_err++;
      $display("FAIL loop_nodone: done pulses=%0d busy=%0b, required 0 0", done_cnt, busy);
    end
    loop = 1'b0;
  endtask

  task automatic test_write_while_busy();
    loop = 1'b0;
    pulse_start();
    repeat (4) @(negedge clock);
    write_entry(0, 99, 9, 1'b0);
    wait_idle(2000, "wbusy_first");
    clear_record();
    pulse_start();
    wait_idle(2000, "wbusy_second");
    n_vec++;
    if (seg_c.size() == 0 || seg_c[0] !== CNT_W'(10) || seg_r[0] != 3) begin
      n_err++;
      $display("FAIL wbusy_entry0: nseg=%0d cuentas=%0d rises=%0d, required cuentas=10 rises=3",
               seg_c.size(), seg_c[0], seg_r[0]);
    end
  endtask

  task automatic test_start_stop_same();
    @(negedge clock);
    start = 1'b1;
    stop  = 1'b1;
    @(negedge clock);
    start = 1'b0;
    stop  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_vec++;
      if (busy !== 1'b0 || presc_reset !== 1'b1) begin
        n_err++;
        $display("FAIL start_stop_c%0d: busy=%0b presc_reset=%0b, required 0 1", i, busy, presc_reset);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 6; it++) begin
      for (int e = 0; e < DEPTH; e++) begin
        int c;
        int r;
        c = $urandom_range(2, 6);
        r = ($urandom_range(0, 9) < 2) ? 0 : $urandom_range(1, 4);
        write_entry(e, c, r, 1'b1);
      end
      loop = 1'b0;
      clear_record();
      pulse_start();
      wait_idle(3000, "random");
      build_expected();
      n_vec++;
      if (seg_c.size() != exp_c.size() || done_cnt != 1) begin
        n_err++;
        $display("FAIL random%0d_shape: nseg=%0d done=%0d, required nseg=%0d done=1",
                 it, seg_c.size(), done_cnt, exp_c.size());
      end
      for (int i = 0; i < exp_c.size(); i++) begin
        n_vec++;
        if (seg_c[i] !== exp_c[i] || seg_r[i] != exp_r[i]) begin
          n_err++;
          $display("FAIL random%0d_seg%0d: cuentas=%0d rises=%0d, required cuentas=%0d rises=%0d",
                   it, i, seg_c[i], seg_r[i], exp_c[i], exp_r[i]);
        end
      end
    end
  endtask

  task automatic test_async_reset();
    int n;
    load_directed_table();
    loop = 1'b0;
    pulse_start();
    n = 0;
    while (!(step_idx == IDX_W'(1) && presc_reset == 1'b0) && n < 2000) begin
      @(negedge clock);
      n++;
    end
    n_vec++;
    if (!(step_idx == IDX_W'(1) && presc_reset == 1'b0)) begin
      n_err++;
      $display("FAIL areset_reach: step_idx=%0d presc_reset=%0b, required 1 0", step_idx, presc_reset);
    end
    #2;
    reset = 1'b0;
    #1;
    n_vec++;
    if ({cuentas, presc_reset, busy, done, step_idx} !== {CNT_W'(0), 1'b1, 1'b0, 1'b0, IDX_W'(0)}) begin
      n_err++;
      $display("FAIL areset_now: cuentas=%0d presc_reset=%0b busy=%0b done=%0b step_idx=%0d, required 0 1 0 0 0",
               cuentas, presc_reset, busy, done, step_idx);
    end
    for (int i = 0; i < DEPTH; i++) begin
      m_cnt[i] = '0;
      m_rep[i] = '0;
    end
    @(negedge clock);
    #2;
    reset = 1'b1;
    @(negedge clock);
    start = 1'b1;
    @(posedge clock);
    #1;
    start = 1'b0;
    n_vec++;
    if (busy !== 1'b1 || presc_reset !== 1'b1 || done !== 1'b0) begin
      n_err++;
      $display("FAIL marker_load: busy=%0b presc_reset=%0b done=%0b, required 1 1 0", busy, presc_reset, done);
    end
    @(posedge clock);
    #1;
    n_vec++;
    if (busy !== 1'b1 || done !== (m_rep[0] == '0)) begin
      n_err++;
      $display("FAIL marker_done: busy=%0b done=%0b, required 1 1", busy, done);
    end
    @(posedge clock);
    #1;
    n_vec++;
    if (busy !== 1'b0 || done !== 1'b0 || cuentas !== m_cnt[0]) begin
      n_err++;
      $display("FAIL marker_idle: busy=%0b done=%0b cuentas=%0d, required 0 0 %0d", busy, done, cuentas, m_cnt[0]);
    end
  endtask

  initial begin
    reset       = 1'b0;
    cfg_we      = 1'b0;
    cfg_addr    = '0;
    cfg_cuentas = '0;
    cfg_reps    = '0;
    start       = 1'b0;
    stop        = 1'b0;
    loop        = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      m_cnt[i] = '0;
      m_rep[i] = '0;
    end
    repeat (3) @(negedge clock);
    test_reset();
    test_directed_sequence();
    test_loop_stop();
    test_write_while_busy();
    test_start_stop_same();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/prescaler_sequencer.md
Name: prescaler_sequencer

Overview:
- Controller that sequences the existing clock prescaler through a programmable table of divisor settings.
- Each table entry holds a count value, which is driven onto the prescaler's 28-bit count input, and a repeat count, the number of prescaler output rising edges to dwell on that entry.
- The block observes the prescaler's output clock and advances entries, then optionally loops; this gives stepped or chirped clock patterns with no CPU involvement.
- Sits between the configuration bus and one prescaler instance.

Parameters:
- CNT_W, 28, width of the count value; matches the prescaler count input.
- REP_W, 16, width of the per-entry repeat count.
- DEPTH, 4, number of table entries; power of two, at least 2.
- IDX_W, 2, log2(DEPTH).

Ports:
- clock  in  1  system clock; the same clock as the prescaler.
- reset  in  1  asynchronous, active-low reset.
- cfg_we  in  1  table write strobe.
- cfg_addr  in  IDX_W  table entry to write.
- cfg_cuentas  in  CNT_W  count value to write.
- cfg_reps  in  REP_W  repeat count to write.
- start  in  1  one-cycle pulse; begins the sequence at entry 0.
- stop  in  1  one-cycle pulse; aborts the sequence.
- loop  in  1  level; sampled at the end of the sequence. 1 = restart at entry 0.
- presc_clk  in  1  prescaler output clock (outCLK).
- cuentas  out  CNT_W  count value to the prescaler.
- presc_reset  out  1  active-high hold to the prescaler reset input.
- busy  out  1  high while the sequence is running.
- step_idx  out  IDX_W  current entry index.
- done  out  1  one-cycle pulse at normal sequence completion.

Behaviour:
- Reset (reset=0, asynchronous) sets:
  - state=IDLE, cuentas=0, presc_reset=1, busy=0, done=0, step_idx=0;
  - edge counter=0, synchroniser flops=0;
  - all table entries=0.
- Table writes:
  - cfg_we=1 writes {cfg_cuentas, cfg_reps} to entry cfg_addr on the clock edge; the write is accepted only in IDLE.
  - cfg_we outside IDLE is ignored and the table is unchanged.
- Edge detection:
  - presc_clk passes through a 2-flop synchroniser, then a previous-value flop.
  - A rise is counted when synced=1 and prev=0.
  - Latency is 3 clock edges from a presc_clk rise to the count increment.
- State machine, states IDLE, LOAD, RUN, DONE:
  - IDLE: presc_reset=1, busy=0. A start pulse gives step_idx=0 and next state LOAD.
  - LOAD (1 cycle): cuentas <= table[step_idx].cuentas; presc_reset=1; edge counter cleared.
    - If table[step_idx].reps==0 (end marker), go to DONE.
    - Otherwise go to RUN.
  - RUN: presc_reset=0, busy=1. Each detected rise increments the edge counter (REP_W bits). On the rise that makes the counter equal reps:
    - if step_idx==DEPTH-1, go to DONE;
    - else step_idx+1, then LOAD.
  - DONE (1 cycle):
    - if loop=1: step_idx=0, then LOAD, and done is not pulsed;
    - else: done=1 for this cycle, then IDLE.
    - cuentas holds its last value.
- busy=1 in LOAD, RUN and DONE.
- A start pulse while busy is ignored.
- A stop pulse in any non-IDLE state:
  - next state IDLE, presc_reset=1 on the next edge, no done pulse;
  - step_idx and cuentas hold their last values for debug.
- start and stop in the same cycle: stop wins. From IDLE this means no start.
- An end marker at entry 0 with loop=0: start leads to LOAD, then DONE with done=1, then IDLE (3 cycles total).
- An end marker at entry 0 with loop=1 cycles LOAD and DONE indefinitely; this is legal, and stop exits it.
- A cuentas value of 0 is passed through unchanged; prescaler behaviour at 0 is the prescaler's concern.
- The edge counter does not wrap in normal operation, because the compare ends RUN at reps ≤ 2^REP_W-1.
- An asynchronous reset mid-sequence returns every output to its reset value immediately.

Decomposition:
- Shared package prescaler_pkg holds:
  - the state encoding constants (IDLE=2'd0, LOAD=2'd1, RUN=2'd2, DONE=2'd3);
  - the default widths CNT_W=28 and REP_W=16.
- One natural sub-module, edge_sync_detect: the 2-flop synchroniser plus rising-edge pulse, with async active-low reset.
- The table (DEPTH x (CNT_W+REP_W) registers), FSM and counter stay in the top level.

Test Plan:
- Reset, then read outputs → cuentas=0, presc_reset=1, busy=0, done=0, step_idx=0.
- Write entry0={10,3}, entry1={20,2}, entry2={0,0}; start with loop=0, driving presc_clk from a real prescaler instance →
  - cuentas=10 for 3 output rises, then cuentas=20 for 2 rises;
  - then done pulses exactly once and busy falls.
- Same table with loop=1 → sequence 10,20,10,20… with no done pulse; a stop pulse → IDLE next cycle, presc_reset=1, no done.
- cfg_we to entry0 with {99,9} while busy → entry0 unchanged; the next pass shows cuentas=10.
- start and stop asserted in the same cycle from IDLE → stays IDLE, busy=0.
- Assert reset low mid-RUN at entry1 → outputs at reset values immediately. A subsequent start with the table cleared behaves as an end marker: LOAD, then DONE, done=1, IDLE.
